sel_mux_pipe: RTL and testbench

Parametrised N-channel, W-bit registered selector with per-channel valid/ready handshakes and one output register stage. It operates in one of two modes. In direct mode the sel input picks the channel. In round-robin mode a built-in arbiter grants fairly among the valid channels. It sits between the register-file/ALU/memory result sources and the write-back path of the mini MIPS datapath, and it supersedes fixed one-bit gate-level muxes where sources are not always ready.

---
 rtl/mips_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/sel_mux_pipe.sv | 91 +++++++++
 tb/tb_sel_mux_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared datapath definitions for the mini MIPS write-back path.
// Selector mode encodings live here so every stage agrees on them.
package mips_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: searches last_grant+1, +2, ... with wrap.
// Purely combinational; indices >= NUM_CH are never produced.
module rr_arbiter #(
  parameter  int NUM_CH = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last_grant,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  int j;

  // Walk from farthest to nearest so the nearest request wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int i = NUM_CH; i >= 1; i--) begin
      j = int'(last_grant) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (req[j]) begin
        gnt_idx = SEL_W'(j);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sel_mux_pipe.sv
// N-channel registered selector with direct or round-robin grant
// and valid/ready handshakes on every channel and on the output.
module sel_mux_pipe
  import mips_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic [SEL_W-1:0] dir_idx;
  logic             dir_any;
  logic [SEL_W-1:0] gnt;
  logic             gnt_any;
  logic             can_accept;
  logic             xfer;

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req       (in_valid),
    .last_grant(last_grant),
    .gnt_idx   (rr_idx),
    .gnt_any   (rr_any)
  );

  // An out-of-range sel matches no k, so it can never grant.
  always_comb begin
    dir_any = 1'b0;
    dir_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(sel) == k && in_valid[k]) begin
        dir_any = 1'b1;
        dir_idx = SEL_W'(k);
      end
    end
  end

  always_comb begin
    unique case (mode)
      MODE_RR: begin
        gnt     = rr_idx;
        gnt_any = rr_any;
      end
      default: begin
        gnt     = dir_idx;
        gnt_any = dir_any;
      end
    endcase
  end

  assign can_accept = !out_valid || out_ready;
  assign xfer       = can_accept && gnt_any;

  always_comb begin
    in_ready = '0;
    if (rst_n && xfer) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= SEL_W'(NUM_CH - 1);
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_data   <= in_data[gnt*WIDTH +: WIDTH];
      out_ch     <= gnt;
      last_grant <= gnt;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Directed bench: vector table for direct mode plus hand-written
// sequences for round-robin, stalls, reset and mode switches.
module tb_sel_mux_pipe;

  logic          clk = 1'b0;
  logic          rst_n;

  logic          mode;
  logic [2:0]    sel;
  logic [255:0]  in_data;
  logic [7:0]    in_valid;
  logic [7:0]    in_ready;
  logic [31:0]   out_data;
  logic [2:0]    out_ch;
  logic          out_valid;
  logic          out_ready;

  logic          mode6;
  logic [2:0]    sel6;
  logic [191:0]  in_data6;
  logic [5:0]    in_valid6;
  logic [5:0]    in_ready6;
  logic [31:0]   out_data6;
  logic [2:0]    out_ch6;
  logic          out_valid6;
  logic          out_ready6;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] valid;
    logic [7:0] exp_rdy;
    logic       exp_ov;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  sel_mux_pipe #(.WIDTH(32), .NUM_CH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .sel      (sel),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  sel_mux_pipe #(.WIDTH(32), .NUM_CH(6)) dut6 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode6),
    .sel      (sel6),
    .in_data  (in_data6),
    .in_valid (in_valid6),
    .in_ready (in_ready6),
    .out_data (out_data6),
    .out_ch   (out_ch6),
    .out_valid(out_valid6),
    .out_ready(out_ready6)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] d8(input int k);
    return 32'hDEAD_0000 | 32'(k);
  endfunction

  function automatic logic [31:0] d6(input int k);
    return 32'hBEEF_0000 | 32'(k);
  endfunction

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  int rr_seq [8] = '{0, 2, 5, 7, 0, 2, 5, 7};

  initial begin
    for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = d8(k);
    for (int k = 0; k < 6; k++) in_data6[k*32 +: 32] = d6(k);
    mode = 1'b1; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
    mode6 = 1'b0; sel6 = 3'd0; in_valid6 = '0; out_ready6 = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("rst_ov",    64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_ch",    64'(out_ch),    64'd0);
    chk("rst_ready", 64'(in_ready),  64'd0);
    in_valid = 8'h00;
    mode = 1'b0;
    rst_n = 1'b1;
    step();

    // Direct-mode vector table
    vecs[0] = '{3'd3, 8'hFF, 8'h08, 1'b1};
    vecs[1] = '{3'd0, 8'h01, 8'h01, 1'b1};
    vecs[2] = '{3'd7, 8'h80, 8'h80, 1'b1};
    vecs[3] = '{3'd5, 8'hDF, 8'h00, 1'b0};
    vecs[4] = '{3'd2, 8'h04, 8'h04, 1'b1};
    vecs[5] = '{3'd6, 8'h00, 8'h00, 1'b0};
    for (int v = 0; v < 6; v++) begin
      mode = 1'b0; out_ready = 1'b1; in_valid = 8'h00;
      step();
      sel = vecs[v].sel;
      in_valid = vecs[v].valid;
      #1;
      chk($sformatf("dir%0d_rdy", v), 64'(in_ready), 64'(vecs[v].exp_rdy));
      step();
      chk($sformatf("dir%0d_ov", v), 64'(out_valid), 64'(vecs[v].exp_ov));
      if (vecs[v].exp_ov) begin
        chk($sformatf("dir%0d_ch", v), 64'(out_ch), 64'(vecs[v].sel));
        chk($sformatf("dir%0d_data", v), 64'(out_data),
            64'(d8(int'(vecs[v].sel))));
      end
    end

    // Round-robin fairness from a fresh pointer
    in_valid = 8'h00;
    pulse_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr%0d_ch", i), 64'(out_ch), 64'(rr_seq[i]));
      chk($sformatf("rr%0d_data", i), 64'(out_data), 64'(d8(rr_seq[i])));
    end
    step(); step(); step();
    chk("pre_rst_ch", 64'(out_ch), 64'd5);

    // Reset in the middle of a pending word
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov",   64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data),  64'd0);
    chk("mid_rst_ch",   64'(out_ch),    64'd0);
    in_valid = 8'hFF; out_ready = 1'b1;
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_ch", 64'(out_ch),    64'd0);
    chk("post_rst_ov", 64'(out_valid), 64'd1);

    // Backpressure: hold three cycles, then reload without a bubble
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_rdy", i), 64'(in_ready), 64'd0);
      step();
      chk($sformatf("stall%0d_ch", i), 64'(out_ch), 64'd0);
      chk($sformatf("stall%0d_data", i), 64'(out_data), 64'(d8(0)));
      chk($sformatf("stall%0d_ov", i), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_rdy", 64'(in_ready), 64'h02);
    step();
    chk("unstall_ch", 64'(out_ch),    64'd1);
    chk("unstall_ov", 64'(out_valid), 64'd1);

    // Single valid channel is granted every cycle
    in_valid = 8'h80;
    step();
    chk("single0_ch", 64'(out_ch), 64'd7);
    step();
    chk("single1_ch", 64'(out_ch), 64'd7);
    chk("single1_ov", 64'(out_valid), 64'd1);

    // Mode switch keeps round-robin fairness
    in_valid = 8'h00;
    pulse_reset();
    mode = 1'b1; in_valid = 8'h04;
    #1;
    chk("ms_rr_rdy", 64'(in_ready), 64'h04);
    step();
    chk("ms_rr_ch", 64'(out_ch), 64'd2);
    mode = 1'b0; sel = 3'd2; in_valid = 8'hFF;
    step();
    chk("ms_dir_ch", 64'(out_ch), 64'd2);
    mode = 1'b1;
    #1;
    chk("ms_back_rdy", 64'(in_ready), 64'h08);
    step();
    chk("ms_back_ch", 64'(out_ch), 64'd3);

    // Six-channel instance: out-of-range select
    mode6 = 1'b0; sel6 = 3'd7; in_valid6 = 6'h3F; out_ready6 = 1'b1;
    #1;
    chk("oor_rdy", 64'(in_ready6), 64'd0);
    step();
    chk("oor_ov", 64'(out_valid6), 64'd0);
    sel6 = 3'd5;
    #1;
    chk("sel5_rdy", 64'(in_ready6), 64'h20);
    step();
    chk("sel5_ov",   64'(out_valid6), 64'd1);
    chk("sel5_ch",   64'(out_ch6),    64'd5);
    chk("sel5_data", 64'(out_data6),  64'(d6(5)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
